// File: rtl/fp_addsub_pipe.sv
// Pipelined IEEE-754 add/subtract: 4 stages, result valid 4 edges after acceptance, 1 op/cycle.
// A single advance (~out_valid | out_ready) freezes every stage while the consumer stalls.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);
  localparam int MW  = MAN_W + 4;
  localparam int EW2 = EXP_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;

  logic w_adv;
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  logic             r1_vld, r1_sub;
  logic [W-1:0]     r1_a, r1_b;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_sa, w_sb, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_nan;
  logic [W-1:0]     w_spc_val;

  assign w_ea    = r1_a[W-2:MAN_W];
  assign w_eb    = r1_b[W-2:MAN_W];
  assign w_fa    = r1_a[MAN_W-1:0];
  assign w_fb    = r1_b[MAN_W-1:0];
  assign w_sa    = r1_a[W-1];
  assign w_sb    = r1_b[W-1] ^ r1_sub;
  assign w_a_inf = (w_ea == EMAX) && (w_fa == '0);
  assign w_b_inf = (w_eb == EMAX) && (w_fb == '0);
  assign w_a_nan = (w_ea == EMAX) && (w_fa != '0);
  assign w_b_nan = (w_eb == EMAX) && (w_fb != '0);
  assign w_nan   = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa != w_sb));
  assign w_spc_val = w_nan   ? {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}} :
                     w_a_inf ? {w_sa, EMAX, {MAN_W{1'b0}}} :
                               {w_sb, EMAX, {MAN_W{1'b0}}};

  logic             r2_vld, r2_sa, r2_sb, r2_spc, r2_inv;
  logic [EXP_W-1:0] r2_xa, r2_xb;
  logic [MAN_W:0]   r2_ma, r2_mb;
  logic [W-1:0]     r2_spc_val;

  // Magnitude order on {exp, mant} is exact because subnormals carry exp 1, hidden 0.
  logic             w_swap, w_sx, w_sy;
  logic [EXP_W-1:0] w_ex, w_ey;
  logic [MAN_W:0]   w_mx, w_my;
  logic [EXP_W:0]   w_diff;
  logic [31:0]      w_shamt;
  logic [2*MW-1:0]  w_wide;
  logic [MW-1:0]    w_my_sh;

  assign w_swap  = {r2_xb, r2_mb} > {r2_xa, r2_ma};
  assign w_ex    = w_swap ? r2_xb : r2_xa;
  assign w_ey    = w_swap ? r2_xa : r2_xb;
  assign w_mx    = w_swap ? r2_mb : r2_ma;
  assign w_my    = w_swap ? r2_ma : r2_mb;
  assign w_sx    = w_swap ? r2_sb : r2_sa;
  assign w_sy    = w_swap ? r2_sa : r2_sb;
  assign w_diff  = {1'b0, w_ex} - {1'b0, w_ey};
  assign w_shamt = (32'(w_diff) > 32'(MW - 1)) ? 32'(MW - 1) : 32'(w_diff);
  assign w_wide  = {w_my, 3'b000, {MW{1'b0}}} >> w_shamt;
  assign w_my_sh = {w_wide[2*MW-1:MW+1], w_wide[MW] | (|w_wide[MW-1:0])};

  logic             r3_vld, r3_sign, r3_zsign, r3_eff_sub, r3_spc, r3_inv;
  logic [EXP_W-1:0] r3_ex;
  logic [MW-1:0]    r3_mx, r3_my;
  logic [W-1:0]     r3_spc_val;
  logic [MW:0]      w_sum;

  assign w_sum = r3_eff_sub ? ({1'b0, r3_mx} - {1'b0, r3_my})
                            : ({1'b0, r3_mx} + {1'b0, r3_my});

  logic             r4_vld, r4_sign, r4_zsign, r4_spc, r4_inv;
  logic [EXP_W-1:0] r4_ex;
  logic [MW:0]      r4_sum;
  logic [W-1:0]     r4_spc_val;

  int               w_lz, w_sh;
  logic [MW-1:0]    w_m;
  logic [EW2-1:0]   w_e;
  logic [MAN_W+1:0] w_rnd;
  logic             w_inx, w_up;
  logic [W-1:0]     w_res;
  logic [2:0]       w_flg;

  always_comb begin
    w_lz  = MW;
    w_sh  = 0;
    w_m   = '0;
    w_e   = '0;
    w_rnd = '0;
    w_inx = 1'b0;
    w_up  = 1'b0;
    w_res = '0;
    w_flg = '0;
    for (int i = 0; i < MW; i++)
      if (r4_sum[i]) w_lz = MW - 1 - i;
    if (r4_sum[MW]) begin
      w_m = r4_sum[MW:1] | MW'(r4_sum[0]);
      w_e = EW2'(r4_ex) + EW2'(1);
    end else begin
      // Left shift stops at exponent 1 so underflowing results come out subnormal.
      w_sh = (w_lz < int'(r4_ex) - 1) ? w_lz : int'(r4_ex) - 1;
      w_m  = r4_sum[MW-1:0] << w_sh;
      w_e  = EW2'(r4_ex) - EW2'(w_sh);
    end
    w_inx = |w_m[2:0];
    w_up  = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    w_rnd = {1'b0, w_m[MW-1:3]} + (MAN_W+2)'(w_up);
    if (w_rnd[MAN_W+1]) begin
      w_rnd = w_rnd >> 1;
      w_e   = w_e + EW2'(1);
    end
    if (r4_spc) begin
      w_res = r4_spc_val;
      w_flg = {r4_inv, 2'b00};
    end else if (w_e >= EW2'(EMAX)) begin
      w_res = {r4_sign, EMAX, {MAN_W{1'b0}}};
      w_flg = 3'b011;
    end else begin
      w_res = {(r4_sum == '0) ? r4_zsign : r4_sign,
               w_rnd[MAN_W] ? w_e[EXP_W-1:0] : {EXP_W{1'b0}},
               w_rnd[MAN_W-1:0]};
      w_flg = {2'b00, w_inx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_vld    <= 1'b0;
      r2_vld    <= 1'b0;
      r3_vld    <= 1'b0;
      r4_vld    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (w_adv) begin
      r1_vld    <= in_valid;
      r2_vld    <= r1_vld;
      r3_vld    <= r2_vld;
      r4_vld    <= r3_vld;
      out_valid <= r4_vld;
      result    <= r4_vld ? w_res : '0;
      flags     <= r4_vld ? w_flg : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r1_a       <= a;
      r1_b       <= b;
      r1_sub     <= sub;
      r2_sa      <= w_sa;
      r2_sb      <= w_sb;
      r2_xa      <= (w_ea == '0) ? EXP_W'(1) : w_ea;
      r2_xb      <= (w_eb == '0) ? EXP_W'(1) : w_eb;
      r2_ma      <= {w_ea != '0, w_fa};
      r2_mb      <= {w_eb != '0, w_fb};
      r2_spc     <= w_nan | w_a_inf | w_b_inf;
      r2_inv     <= w_nan;
      r2_spc_val <= w_spc_val;
      r3_sign    <= w_sx;
      r3_zsign   <= r2_sa & r2_sb;
      r3_eff_sub <= w_sx ^ w_sy;
      r3_ex      <= w_ex;
      r3_mx      <= {w_mx, 3'b000};
      r3_my      <= w_my_sh;
      r3_spc     <= r2_spc;
      r3_inv     <= r2_inv;
      r3_spc_val <= r2_spc_val;
      r4_sign    <= r3_sign;
      r4_zsign   <= r3_zsign;
      r4_ex      <= r3_ex;
      r4_sum     <= w_sum;
      r4_spc     <= r3_spc;
      r4_inv     <= r3_inv;
      r4_spc_val <= r3_spc_val;
    end
  end
endmodule
